// File: rtl/rf_access_seq.sv
// -----------------------------------------------------------------------------
// rf_access_seq
//   Sequencer for an 8x8 dual-port register file. It takes one register-file
//   operation per start pulse and drives the file's control pins (clr, we,
//   mux_sel, read_seg, write_seg) cycle by cycle. For ALU operations it reads
//   the operand and then waits for the ALU result. For loads it waits for data
//   memory. Only one operation is in flight at a time.
//
// Ports
//   clk           in   clock; all state changes on the rising edge
//   clr_n         in   asynchronous active-low reset
//   start         in   operation request; sampled only in IDLE
//   op[2:0]       in   operation code
//   rn[2:0]       in   register index N
//   alu_done      in   ALU result valid (honoured only in ALU)
//   mem_ack       in   memory data valid (honoured only in MEM)
//   rf_clr        out  register-file clear
//   rf_we         out  register-file write enable
//   rf_mux_sel    out  register-file write-data select
//   rf_read_seg   out  register-file read index (latched rn)
//   rf_write_seg  out  register-file write index
//   alu_go        out  level request to the ALU
//   mem_req       out  level request to data memory
//   busy          out  operation in progress (non-IDLE)
//   done          out  one-cycle completion pulse
//   err           out  one-cycle pulse, coincident with done, on timeout
//   dbg_state     out  current FSM state, for observation only
//
// Handshakes
//   alu_go/alu_done and mem_req/mem_ack are level request / acknowledge pairs.
//   A request is raised on entry to its wait state and is held until the
//   acknowledge is sampled high on a rising edge, or until the wait times out.
//   An acknowledge that arrives while no request is pending is ignored.
//   Memory keeps its data valid until mem_req falls, so mem_req stays high
//   through the write cycle that follows a load.
//   Every output is a Moore decode of state plus the latched op/rn.
// -----------------------------------------------------------------------------
module rf_access_seq #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] rn,
  input  logic       alu_done,
  input  logic       mem_ack,
  output logic       rf_clr,
  output logic       rf_we,
  output logic [2:0] rf_mux_sel,
  output logic [2:0] rf_read_seg,
  output logic [2:0] rf_write_seg,
  output logic       alu_go,
  output logic       mem_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_ALU  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_CLR  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam logic [2:0] OP_ALU = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  // Counter value seen on the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic [2:0]       r_rn;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [2:0]       w_next;
  logic             w_wait;
  logic             w_ack;
  logic             w_timeout;
  logic             w_enter_wait;

  assign w_wait       = (r_state == S_ALU) || (r_state == S_MEM);
  assign w_ack        = (r_state == S_ALU) ? alu_done : mem_ack;
  // An acknowledge on the final wait cycle still wins over the timeout.
  assign w_timeout    = w_wait && !w_ack && (r_cnt == CNT_LAST);
  assign w_enter_wait = (r_state != w_next) &&
                        ((w_next == S_ALU) || (w_next == S_MEM));

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next = S_IDLE;
        if (start) begin
          case (op)
            OP_ALU:  w_next = S_RD;
            OP_LD:   w_next = S_MEM;
            OP_CLR:  w_next = S_CLR;
            default: w_next = S_WR;
          endcase
        end
      end
      S_RD:  w_next = S_ALU;
      S_ALU, S_MEM: begin
        if (w_ack)          w_next = S_WR;
        else if (w_timeout) w_next = S_FIN;
        else                w_next = r_state;
      end
      S_WR:    w_next = S_FIN;
      S_CLR:   w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_rn    <= 3'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start) begin
        r_op <= op;
        r_rn <= rn;
      end
      if (w_enter_wait)
        r_cnt <= '0;
      else if (w_wait)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
      else if (r_state == S_FIN)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    rf_clr       = 1'b0;
    rf_we        = 1'b0;
    rf_mux_sel   = 3'd0;
    rf_write_seg = 3'd0;
    alu_go       = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_ALU: alu_go = 1'b1;
      S_MEM: mem_req = 1'b1;
      S_WR: begin
        rf_we      = 1'b1;
        rf_mux_sel = r_op;
        // ops 100/101 always target R0
        rf_write_seg = (r_op[2:1] == 2'b10) ? 3'd0 : r_rn;
        mem_req    = (r_op == OP_LD);
      end
      S_CLR: rf_clr = 1'b1;
      S_FIN: begin
        done = 1'b1;
        err  = r_err;
      end
      default: begin
        rf_clr = 1'b0;
      end
    endcase
  end

  assign rf_read_seg = r_rn;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rf_access_seq.sv
module tb_rf_access_seq;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic [2:0] op;
  logic [2:0] rn;
  logic       alu_done;
  logic       mem_ack;
  logic       rf_clr;
  logic       rf_we;
  logic [2:0] rf_mux_sel;
  logic [2:0] rf_read_seg;
  logic [2:0] rf_write_seg;
  logic       alu_go;
  logic       mem_req;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int n_vec;
  int n_err;

  // Transaction word: {err, clr pulses[1:0], we pulses[1:0], mux[2:0], seg[2:0]}
  logic [10:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rf_access_seq #(.TIMEOUT_CYC(15), .CNT_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .rn(rn),
    .alu_done(alu_done), .mem_ack(mem_ack),
    .rf_clr(rf_clr), .rf_we(rf_we), .rf_mux_sel(rf_mux_sel),
    .rf_read_seg(rf_read_seg), .rf_write_seg(rf_write_seg),
    .alu_go(alu_go), .mem_req(mem_req), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_word(input logic [2:0] o, input logic [2:0] r,
                                           input logic e);
    logic [2:0] seg;
    if (e) return {1'b1, 2'd0, 2'd0, 3'd0, 3'd0};
    if (o == 3'b111) return {1'b0, 2'd1, 2'd0, 3'd0, 3'd0};
    seg = (o == 3'b100 || o == 3'b101) ? 3'd0 : r;
    return {1'b0, 2'd0, 2'd1, o, seg};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [1:0] mon_we;
  logic [1:0] mon_clr;
  logic [2:0] mon_mux;
  logic [2:0] mon_seg;

  always @(negedge clk) begin
    if (!clr_n) begin
      mon_we = 2'd0; mon_clr = 2'd0; mon_mux = 3'd0; mon_seg = 3'd0;
    end else begin
      if (rf_we) begin
        mon_we = mon_we + 2'd1; mon_mux = rf_mux_sel; mon_seg = rf_write_seg;
      end
      if (rf_clr) mon_clr = mon_clr + 2'd1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("sb_txn", {21'd0, err, mon_clr, mon_we, mon_mux, mon_seg},
              {21'd0, exp_q.pop_front()});
        end
        mon_we = 2'd0; mon_clr = 2'd0; mon_mux = 3'd0; mon_seg = 3'd0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    start = 1'b0; op = 3'd0; rn = 3'd0; alu_done = 1'b0; mem_ack = 1'b0;
    repeat (2) tick();
    clr_n = 1'b1;
    tick();
  endtask

  // One op: start pulse, then respond to the wait state after d idle wait cycles.
  task automatic run_op(input logic [2:0] o, input logic [2:0] r, input int d,
                        input logic stray);
    int w;
    bit got;
    logic e;
    e = ((o == 3'b011) || (o == 3'b110)) && (d >= 15);
    exp_q.push_back(exp_word(o, r, e));
    start = 1'b1; op = o; rn = r;
    alu_done = stray; mem_ack = stray;
    w = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      start = 1'b0;
      alu_done = 1'b0; mem_ack = 1'b0;
      if (done) begin got = 1; break; end
      if ((alu_go || mem_req) && !rf_we) begin
        w++;
        if (w == d + 1) begin alu_done = alu_go; mem_ack = mem_req; end
      end else if (stray && !alu_go && !mem_req) begin
        alu_done = 1'b1; mem_ack = 1'b1;
      end
    end
    alu_done = 1'b0; mem_ack = 1'b0;
    if (!got) chk("run_op_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // ---------------- directed + random sequences ----------------
  initial begin
    n_vec = 0; n_err = 0;
    do_reset();
    chk("rst_outputs", {rf_clr, rf_we, rf_mux_sel, rf_read_seg, rf_write_seg,
                        alu_go, mem_req, busy, done, err}, 32'd0);
    chk("rst_state", dbg_state, 3'd0);

    // op=001 rn=5: WR @T+1, done @T+2
    exp_q.push_back(exp_word(3'b001, 3'd5, 1'b0));
    start = 1'b1; op = 3'b001; rn = 3'd5;
    tick(); start = 1'b0;
    chk("b_wr", {busy, rf_we, rf_mux_sel, rf_write_seg, done}, {1'b1, 1'b1, 3'b001, 3'd5, 1'b0});
    tick();
    chk("b_fin", {busy, rf_we, done, err}, 4'b1010);
    tick();
    chk("b_idle", {busy, done}, 2'b00);

    // op=011 rn=3, alu_done on third ALU cycle
    exp_q.push_back(exp_word(3'b011, 3'd3, 1'b0));
    start = 1'b1; op = 3'b011; rn = 3'd3;
    tick(); start = 1'b0;
    chk("alu_rd", {rf_read_seg, alu_go, rf_we, busy}, {3'd3, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alu_go_held", {alu_go, rf_we}, 2'b10);
    end
    alu_done = 1'b1;
    tick(); alu_done = 1'b0;
    chk("alu_wr", {rf_we, rf_mux_sel, rf_write_seg, alu_go}, {1'b1, 3'b011, 3'd3, 1'b0});
    tick();
    chk("alu_fin", {done, err}, 2'b10);
    tick();

    // op=110 rn=7, no ack: 15 MEM cycles then FIN with err
    exp_q.push_back(exp_word(3'b110, 3'd7, 1'b1));
    start = 1'b1; op = 3'b110; rn = 3'd7;
    for (int i = 0; i < 15; i++) begin
      tick(); start = 1'b0;
      chk("mem_wait", {mem_req, rf_we, done}, 3'b100);
    end
    tick();
    chk("mem_to", {done, err, rf_we, mem_req}, 4'b1100);
    tick();

    // op=110 rn=7, ack on the 15th MEM cycle wins
    exp_q.push_back(exp_word(3'b110, 3'd7, 1'b0));
    start = 1'b1; op = 3'b110; rn = 3'd7;
    for (int i = 0; i < 15; i++) begin
      tick(); start = 1'b0;
      chk("mem_wait2", {mem_req, rf_we}, 2'b10);
    end
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("mem_wr", {rf_we, rf_mux_sel, rf_write_seg, mem_req}, {1'b1, 3'b110, 3'd7, 1'b1});
    tick();
    chk("mem_fin", {done, err, mem_req}, 3'b100);
    tick();

    // op=100 rn=6 targets R0
    exp_q.push_back(exp_word(3'b100, 3'd6, 1'b0));
    start = 1'b1; op = 3'b100; rn = 3'd6;
    tick(); start = 1'b0;
    chk("sp_wr", {rf_we, rf_mux_sel, rf_write_seg}, {1'b1, 3'b100, 3'd0});
    tick(); tick();

    // op=111 clear, with a start attempt while busy
    exp_q.push_back(exp_word(3'b111, 3'd4, 1'b0));
    start = 1'b1; op = 3'b111; rn = 3'd4;
    tick();
    chk("clr_pulse", {rf_clr, rf_we}, 2'b10);
    op = 3'b000; rn = 3'd2;   // start still high: must be ignored
    tick(); start = 1'b0;
    chk("clr_fin", {rf_clr, done}, 2'b01);
    tick();
    chk("busy_ignored", {busy, rf_read_seg}, {1'b0, 3'd4});

    // back-to-back with start held high: period IDLE/WR/FIN
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] o;
      case ($urandom_range(0, 4))
        0: o = 3'b000; 1: o = 3'b001; 2: o = 3'b010; 3: o = 3'b100; default: o = 3'b101;
      endcase
      op = o; rn = 3'($urandom_range(0, 7));
      exp_q.push_back(exp_word(op, rn, 1'b0));
      chk("b2b_idle", busy, 1'b0);
      tick();
      chk("b2b_wr", rf_we, 1'b1);
      tick();
      chk("b2b_fin", done, 1'b1);
      if (k == 5) start = 1'b0;
      tick();
    end
    tick();

    // random ops with random ack delay and stray acks
    for (int k = 0; k < 12; k++) begin
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 17), 1'($urandom_range(0, 1)));
    end

    // async reset in the middle of an ALU wait
    start = 1'b1; op = 3'b011; rn = 3'd2;
    tick(); start = 1'b0;
    tick(); tick();
    #2 clr_n = 1'b0;
    #1;
    chk("arst_outputs", {rf_clr, rf_we, rf_mux_sel, rf_read_seg, rf_write_seg,
                         alu_go, mem_req, busy, done, err}, 32'd0);
    chk("arst_state", dbg_state, 3'd0);
    tick(); tick();
    clr_n = 1'b1;
    repeat (4) tick();
    chk("arst_no_we", {mon_we, mon_clr, busy}, 5'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
